// File: rtl/display_pkg.sv
// Shared widths and FSM encodings for the display value scheduler and its
// shared binary-to-BCD converter.
package display_pkg;
  localparam int VAL_W      = 16;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_CONVERT = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
endpackage

// File: rtl/display_value_scheduler_conv.sv
// Iterative double-dabble converter: one input bit per cycle, VAL_W cycles
// after start. done flags the cycle in which the final shift happens.
module bcd_shift_converter
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  logic [VAL_W-1:0] bin;
  logic [3:0]       cnt;
  logic             run;
  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < BCD_DIGITS; d++)
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
  end

  assign done = run && (cnt == 4'(VAL_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      bin <= value;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      {bcd, bin} <= {adj, bin} << 1;
      cnt        <= cnt + 4'd1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/display_value_scheduler.sv
// Round-robin scheduler sharing one BCD converter among NUM_SRC book values;
// each result is latched and held on display for HOLD_CYCLES.
module display_value_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [VAL_W*NUM_SRC-1:0]   src_val,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic                       freeze,
  output logic [BCD_W-1:0]           bcd_out,
  output logic [$clog2(NUM_SRC)-1:0] src_sel,
  output logic                       busy,
  output logic                       update
);
  localparam int SEL_W = $clog2(NUM_SRC);

  logic [2:0]       state;
  logic [SEL_W-1:0] last, cur, nxt, hi_idx, lo_idx;
  logic             hi_ok, any;
  logic [31:0]      hold_cnt;
  logic [VAL_W-1:0] vals [NUM_SRC];
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_val
    assign vals[i] = src_val[VAL_W*i +: VAL_W];
  end

  // Next grant: lowest valid index above the last grant, else lowest valid
  // overall (which re-grants a lone source).
  always_comb begin
    hi_idx = '0;
    hi_ok  = 1'b0;
    lo_idx = '0;
    any    = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        lo_idx = SEL_W'(i);
        any    = 1'b1;
        if (SEL_W'(i) > last) begin
          hi_idx = SEL_W'(i);
          hi_ok  = 1'b1;
        end
      end
    end
  end
  assign nxt = hi_ok ? hi_idx : lo_idx;

  assign busy = (state == S_SELECT) || (state == S_CONVERT) || (state == S_LATCH);

  bcd_shift_converter u_conv (
    .clk   (clk),
    .rst   (rst),
    .start ((state == S_SELECT) && any),
    .value (vals[nxt]),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      last     <= SEL_W'(NUM_SRC - 1);
      cur      <= '0;
      bcd_out  <= '0;
      src_sel  <= '0;
      update   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      update <= 1'b0;
      case (state)
        S_IDLE: if (|src_valid) state <= S_SELECT;
        S_SELECT: begin
          if (any) begin
            cur   <= nxt;
            last  <= nxt;
            state <= S_CONVERT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CONVERT: if (conv_done) state <= S_LATCH;
        S_LATCH: begin
          bcd_out  <= conv_bcd;
          src_sel  <= cur;
          update   <= 1'b1;
          hold_cnt <= 32'(HOLD_CYCLES - 1);
          state    <= S_HOLD;
        end
        S_HOLD: begin
          // freeze pauses both the countdown and the early exit on a drop
          if (!freeze) begin
            if (!src_valid[src_sel] || hold_cnt == '0) state <= S_SELECT;
            else hold_cnt <= hold_cnt - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_display_value_scheduler.sv
// Scoreboard bench: expected (src_sel, bcd) pairs are queued as stimulus is
// set up and compared on every update pulse; timing is checked in cycles.
module tb_display_value_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] src_val;
  logic [3:0]  src_valid;
  logic        freeze;
  logic [19:0] bcd_out;
  logic [1:0]  src_sel;
  logic        busy;
  logic        update;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_bcd[$];
  int exp_sel[$];
  logic prev_upd = 1'b0;

  display_value_scheduler #(.NUM_SRC(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .src_val(src_val), .src_valid(src_valid),
    .freeze(freeze), .bcd_out(bcd_out), .src_sel(src_sel), .busy(busy),
    .update(update)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    return {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic push(input int sel, input int v);
    exp_sel.push_back(sel);
    exp_bcd.push_back(int'(to_bcd(v)));
  endtask

  // Scoreboard side: every update must match the oldest queued expectation.
  always @(negedge clk) begin
    if (update) begin
      chk("no_double_update", {31'd0, prev_upd}, 32'd0);
      if (exp_bcd.size() == 0) begin
        chk("unexpected_update", 32'd1, 32'd0);
      end else begin
        chk("bcd_out", {12'd0, bcd_out}, 32'(exp_bcd.pop_front()));
        chk("src_sel", {30'd0, src_sel}, 32'(exp_sel.pop_front()));
      end
    end
    prev_upd <= update;
  end

  task automatic wait_upd(output int at);
    int n = 0;
    @(negedge clk);
    while (!update && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!update) chk("update_timeout", 32'd0, 32'd1);
    at = cyc;
  endtask

  task automatic wait_busy(output int at);
    int n = 0;
    @(negedge clk);
    while (!busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!busy) chk("busy_timeout", 32'd0, 32'd1);
    at = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, u;
    int seen;
    rst = 1'b1;
    src_val = '0;
    src_valid = '0;
    freeze = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", {12'd0, bcd_out}, 32'd0);
    chk("rst_sel", {30'd0, src_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_update", {31'd0, update}, 32'd0);
    rst = 1'b0;

    // No valid source: nothing happens.
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || update) seen++;
    end
    chk("idle_activity", 32'(seen), 32'd0);
    chk("idle_bcd", {12'd0, bcd_out}, 32'd0);

    // Single source: latency and period.
    src_val[15:0] = 16'd12345;
    src_valid = 4'b0001;
    push(0, 12345);
    wait_busy(t0);
    wait_upd(t1);
    chk("latency", 32'(t1 - t0), 32'd18);
    chk("busy_in_hold", {31'd0, busy}, 32'd0);
    push(0, 12345);
    wait_upd(t2);
    chk("period", 32'(t2 - t1), 32'd22);

    // Boundary values; the change made during CONVERT must not leak in.
    src_val[15:0] = 16'd65535;
    push(0, 65535);
    repeat (8) @(negedge clk);
    src_val[15:0] = 16'd0;
    push(0, 0);
    wait_upd(t1);
    chk("period_65535", 32'(t1 - t2), 32'd22);
    wait_upd(u);
    src_val[15:0] = 16'd9;
    push(0, 9);
    wait_upd(u);
    src_valid = 4'b0000;
    repeat (30) @(negedge clk);

    // Round robin over 1011 from reset: 0,1,3,0,1.
    do_reset();
    src_val = {16'd400, 16'd300, 16'd200, 16'd100};
    src_valid = 4'b1011;
    push(0, 100); push(1, 200); push(3, 400); push(0, 100); push(1, 200);
    repeat (5) wait_upd(u);
    src_valid = 4'b0000;
    repeat (30) @(negedge clk);

    // Freeze delays the next update by exactly the frozen cycles.
    src_val[63:48] = 16'd777;
    src_valid = 4'b1000;
    push(3, 777); push(3, 777);
    wait_upd(t1);
    freeze = 1'b1;
    repeat (10) @(negedge clk);
    freeze = 1'b0;
    wait_upd(t2);
    chk("freeze_delay", 32'(t2 - t1), 32'd32);

    // Dropping the shown source leaves HOLD on the next cycle.
    src_val[15:0] = 16'd555;
    src_valid = 4'b0001;
    push(0, 555);
    @(negedge clk);
    chk("drop_select", {31'd0, busy}, 32'd1);
    wait_upd(t1);
    chk("drop_latency", 32'(t1 - t2), 32'd19);
    src_valid = 4'b0000;
    repeat (30) @(negedge clk);

    // Reset during conversion aborts at once; conversion restarts after.
    src_val[15:0] = 16'd54321;
    src_valid = 4'b0001;
    wait_busy(t0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_bcd", {12'd0, bcd_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sel", {30'd0, src_sel}, 32'd0);
    repeat (2) @(negedge clk);
    push(0, 54321);
    rst = 1'b0;
    wait_upd(u);
    src_valid = 4'b0000;
    repeat (30) @(negedge clk);

    chk("queue_empty", 32'(exp_bcd.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
